// File: rtl/fdc_buffer_ctrl.sv
// Ping-pong sector buffer between an SD card engine and a floppy controller.
// Two 512-byte halves in a dual-port RAM; the producer fills one half while the consumer drains the other.
module fdc_buffer_ctrl #(
  parameter int unsigned SECT_BITS = 9
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 dir,
  input  logic                 sd_stb,
  input  logic [7:0]           sd_din,
  output logic [7:0]           sd_dout,
  output logic                 sd_ready,
  input  logic                 fdc_stb,
  input  logic [7:0]           fdc_din,
  output logic [7:0]           fdc_dout,
  output logic                 fdc_ready,
  output logic [SECT_BITS:0]   ram_ada,
  output logic [SECT_BITS:0]   ram_adb,
  output logic                 ram_cea,
  output logic                 ram_ceb,
  output logic                 ram_wrea,
  output logic                 ram_wreb,
  output logic [7:0]           ram_dina,
  output logic [7:0]           ram_dinb,
  input  logic [7:0]           ram_douta,
  input  logic [7:0]           ram_doutb,
  output logic [1:0]           buf_full,
  output logic                 overrun,
  output logic                 active
);

  typedef enum logic {IDLE, XFER} state_t;

  state_t                 state;
  logic                   dir_q;
  logic                   p_idx, c_idx;
  logic [SECT_BITS-1:0]   p_cnt, c_cnt;
  logic [1:0]             full;
  logic                   ovr;

  logic                   xfer, ctl, prod_rdy, cons_rdy;
  logic                   sd_acc, fdc_acc, prod_acc, cons_acc;
  logic                   ovr_evt;
  logic [1:0]             full_nx;
  logic [SECT_BITS:0]     p_addr, c_addr;

  // Roles are fixed by the latched direction; start/abort cycles swallow strobes.
  always_comb begin
    xfer     = (state == XFER);
    ctl      = start | abort;
    prod_rdy = xfer && !full[p_idx];
    cons_rdy = xfer && full[c_idx];
    sd_ready  = dir_q ? cons_rdy : prod_rdy;
    fdc_ready = dir_q ? prod_rdy : cons_rdy;
    sd_acc   = sd_stb  && sd_ready  && !ctl;
    fdc_acc  = fdc_stb && fdc_ready && !ctl;
    prod_acc = dir_q ? fdc_acc : sd_acc;
    cons_acc = dir_q ? sd_acc  : fdc_acc;
    ovr_evt  = xfer && !ctl && ((sd_stb && !sd_ready) || (fdc_stb && !fdc_ready));
    p_addr   = {p_idx, p_cnt};
    c_addr   = {c_idx, c_cnt};

    full_nx = full;
    if (prod_acc && (&p_cnt)) full_nx[p_idx] = 1'b1;
    if (cons_acc && (&c_cnt)) full_nx[c_idx] = 1'b0;

    ram_cea  = sd_acc;
    ram_wrea = sd_acc && !dir_q;
    ram_ada  = dir_q ? c_addr : p_addr;
    ram_dina = sd_din;
    ram_ceb  = fdc_acc;
    ram_wreb = fdc_acc && dir_q;
    ram_adb  = dir_q ? p_addr : c_addr;
    ram_dinb = fdc_din;

    sd_dout  = ram_douta;
    fdc_dout = ram_doutb;
    buf_full = full;
    overrun  = ovr;
    active   = xfer;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      dir_q <= 1'b0;
      p_idx <= 1'b0;
      c_idx <= 1'b0;
      p_cnt <= '0;
      c_cnt <= '0;
      full  <= '0;
      ovr   <= 1'b0;
    end else if (abort) begin
      state <= IDLE;
      p_idx <= 1'b0;
      c_idx <= 1'b0;
      p_cnt <= '0;
      c_cnt <= '0;
      full  <= '0;
    end else if (start) begin
      state <= XFER;
      dir_q <= dir;
      p_idx <= 1'b0;
      c_idx <= 1'b0;
      p_cnt <= '0;
      c_cnt <= '0;
      full  <= '0;
      ovr   <= 1'b0;
    end else begin
      if (prod_acc) begin
        p_cnt <= p_cnt + 1'b1;
        if (&p_cnt) p_idx <= ~p_idx;
      end
      if (cons_acc) begin
        c_cnt <= c_cnt + 1'b1;
        if (&c_cnt) c_idx <= ~c_idx;
      end
      full <= full_nx;
      if (ovr_evt) ovr <= 1'b1;
    end
  end

endmodule

// File: doc/fdc_buffer_ctrl.md
FDC_BUFFER_CTRL -- requirements
Module: fdc_buffer_ctrl

Interface
REQ-001 The block SHALL have parameter SECT_BITS, default 9, meaning log2 of sector size; RAM address width is SECT_BITS+1 (10, i.e. 1024x8 dual-port RAM).
REQ-002 The block SHALL have these ports:
- clk  in  1  sole clock; all logic on rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse: begin transfer session, latch dir
- abort  in  1  one-cycle pulse: end session, return to IDLE
- dir  in  1  0 = disk read (SD produces, FDC consumes); 1 = disk write (FDC produces, SD consumes)
- sd_stb  in  1  SD-side byte strobe
- sd_din  in  8  SD-side write byte
- sd_dout  out  8  SD-side read byte
- sd_ready  out  1  SD side may strobe
- fdc_stb  in  1  FDC-side byte strobe
- fdc_din  in  8  FDC-side write byte
- fdc_dout  out  8  FDC-side read byte
- fdc_ready  out  1  FDC side may strobe
- ram_ada / ram_adb  out  10  RAM port A (SD) / port B (FDC) address
- ram_cea / ram_ceb  out  1  RAM clock enables
- ram_wrea / ram_wreb  out  1  RAM write enables
- ram_dina / ram_dinb  out  8  RAM write data
- ram_douta / ram_doutb  in  8  RAM read data (1-cycle latency, no output register)
- buf_full  out  2  per-half full flags
- overrun  out  1  sticky: strobe received while not ready
- active  out  1  high in XFER state

Function
REQ-003 RAM SHALL be split into two sector halves: half 0 = 0..511, half 1 = 512..1023; address = {idx, cnt[8:0]}.
REQ-004 States SHALL be IDLE and XFER; IDLE -> XFER on start; XFER -> IDLE on abort; XFER -> XFER on start (restart).
REQ-005 On start (either state): dir latched, p_idx=c_idx=0, p_cnt=c_cnt=0, buf_full=00, overrun=0.
REQ-006 Producer = SD if latched dir=0 else FDC; consumer = the other side; roles fixed until next start.
REQ-007 Producer ready SHALL be (state==XFER) && !buf_full[p_idx]; consumer ready SHALL be (state==XFER) && buf_full[c_idx]; sd_ready/fdc_ready map to the role of each side; both 0 in IDLE.
REQ-008 Accepted producer strobe: same cycle ce=1, we=1, addr={p_idx,p_cnt}, din=side's input byte; p_cnt increments.
REQ-009 When p_cnt=511 on accepted producer strobe: p_cnt wraps to 0, buf_full[p_idx] set, p_idx toggles, all at the same edge.
REQ-010 Accepted consumer strobe: same cycle ce=1, we=0, addr={c_idx,c_cnt}; byte valid on side's dout the following cycle and held until next read.
REQ-011 When c_cnt=511 on accepted consumer strobe: c_cnt wraps to 0, buf_full[c_idx] cleared, c_idx toggles.
REQ-012 Simultaneous producer completion and consumer completion SHALL both take effect in the same cycle (they always target different halves).
REQ-013 Strobe on a side whose ready is 0 SHALL NOT access RAM or change counters and SHALL set overrun (in XFER only); overrun stays set until start or reset.
REQ-014 ce and we SHALL be 0 on every cycle without an accepted strobe.
REQ-015 start and abort in the same cycle: abort wins; start or abort coincident with a strobe: strobe ignored, no overrun.
REQ-016 abort SHALL clear buf_full, counters and indices; overrun retained.
REQ-017 sd_dout/fdc_dout SHALL be driven from ram_douta/ram_doutb directly.

Reset
REQ-018 reset_n low SHALL asynchronously force IDLE, dir latch 0, counters/indices 0, buf_full=00, overrun=0, all RAM ce/we=0, all ready=0, active=0.
REQ-019 Reset SHALL act mid-transfer with no RAM write issued on the cycle reset_n deasserts.

Verification
REQ-020 Read flow: start dir=0; 512 sd_stb with bytes n&0xFF -> buf_full=01, fdc_ready=1; 512 fdc_stb -> fdc_dout sequence 0x00..0xFF twice, buf_full=00.
REQ-021 Ping-pong: 1024 SD bytes without FDC activity -> buf_full=11, sd_ready=0; one extra sd_stb -> overrun=1, no RAM write.
REQ-022 Write flow: start dir=1; FDC writes 512 bytes 0xA5 -> sd_ready=1, SD reads 0xA5 x512 with 1-cycle latency, addresses 0..511 on port A.
REQ-023 Concurrent: SD completes half 1 on the same cycle FDC completes half 0 -> buf_full goes 01 -> 10 in one edge.
REQ-024 Abort after 300 producer bytes, then start -> counters 0, buf_full=00, next write at address 0.
REQ-025 reset_n pulsed low during XFER with buf_full=01 -> all outputs at REQ-018 values immediately, no clock needed.
